// File: rtl/reaction_pkg.sv
// -----------------------------------------------------------------------------
// reaction_pkg
// Shared definitions for the reaction-timer controller:
//   - state_e      : controller states
//   - LFSR_SEED    : reset value of the pseudo-random generator
//   - LFSR_TAPS    : Galois feedback mask for x^16+x^14+x^13+x^11+1
//   - NINES_DEFAULT: display code shown after a false start
//   - lfsr_next()  : one step of the right-shifting Galois LFSR
// -----------------------------------------------------------------------------
package reaction_pkg;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    RAND_WAIT    = 3'd1,
    PRESS_WAIT   = 3'd2,
    SHOW_TIME    = 3'd3,
    SHOW_JUMP    = 3'd4,
    SHOW_TIMEOUT = 3'd5,
    SHOW_AVG     = 3'd6
  } state_e;

  localparam logic [15:0] LFSR_SEED     = 16'hACE1;
  // Bits 15,13,12,10 correspond to x^16, x^14, x^13, x^11 in a right shift.
  localparam logic [15:0] LFSR_TAPS     = 16'hB400;
  localparam int unsigned NINES_DEFAULT = 32'd9999;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    lfsr_next = {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/reaction_timer_fsm_lfsr16.sv
// -----------------------------------------------------------------------------
// lfsr16
// Free-running 16-bit Galois LFSR that advances on every clock.
// Ports:
//   clk : system clock
//   rst : synchronous active-high reset, loads LFSR_SEED
//   q   : current LFSR state
// -----------------------------------------------------------------------------
module lfsr16
  import reaction_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] q
);

  logic [15:0] q_q;

  // LFSR state register: seed on reset, otherwise one Galois step per clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= LFSR_SEED;
    end else begin
      q_q <= lfsr_next(q_q);
    end
  end

  assign q = q_q;

endmodule

// File: rtl/reaction_timer_fsm.sv
// -----------------------------------------------------------------------------
// reaction_timer_fsm
// Reaction-game controller: waits a pseudo-random time, lights the LED,
// measures the player's reaction in ms, flags false starts and timeouts, and
// averages the valid times over a series of ROUNDS rounds.
// Optional feature macro: REACTION_BEST_EN (track best valid time since reset;
// when undefined, best stays all-ones and no comparator is built).
// Ports:
//   clk       : system clock
//   rst       : synchronous active-high reset
//   ms_tick   : one-cycle pulse every millisecond
//   start     : start / next-round request (single cycle)
//   stop      : player press (single cycle)
//   led       : stimulus LED
//   num       : value to display
//   hi        : error flag (num shows NINES or TIMEOUT_MS)
//   done      : series complete, num holds the average
//   round_idx : current round number
//   best      : best valid time since reset
// -----------------------------------------------------------------------------
module reaction_timer_fsm
  import reaction_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned TIMEOUT_MS  = 1000,
  parameter int unsigned RAND_MIN_MS = 1000,
  parameter int unsigned RAND_W      = 12,
  parameter int unsigned NINES       = NINES_DEFAULT,
  parameter int unsigned ROUNDS      = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ms_tick,
  input  logic             start,
  input  logic             stop,
  output logic             led,
  output logic [CNT_W-1:0] num,
  output logic             hi,
  output logic             done,
  output logic [3:0]       round_idx,
  output logic [CNT_W-1:0] best
);

  localparam int unsigned      SUM_W      = CNT_W + 4;
  localparam int unsigned      AVG_SH     = $clog2(ROUNDS);
  localparam logic [CNT_W-1:0] TIMEOUT_V  = CNT_W'(TIMEOUT_MS);
  localparam logic [CNT_W-1:0] NINES_V    = CNT_W'(NINES);
  localparam logic [CNT_W-1:0] RAND_MIN_V = CNT_W'(RAND_MIN_MS);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [3:0]       LAST_ROUND = 4'(ROUNDS - 1);
  localparam logic [15:0]      RAND_MASK  = 16'((32'd1 << RAND_W) - 32'd1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] ms_cnt_q, ms_cnt_d;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic             led_q, led_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic             hi_q, hi_d;
  logic             done_q, done_d;
  logic [3:0]       round_q, round_d;
  logic [CNT_W-1:0] best_q, best_d;

  logic [15:0]      lfsr_s;
  logic [SUM_W-1:0] sum_new_s;
  logic [CNT_W-1:0] best_next_s;

  lfsr16 u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr_s)
  );

  // Running total including the time being recorded this cycle.
  assign sum_new_s = sum_q + SUM_W'(ms_cnt_q);

`ifdef REACTION_BEST_EN
  assign best_next_s = (ms_cnt_q < best_q) ? ms_cnt_q : best_q;
`else
  assign best_next_s = best_q;
`endif

  // Next-state and next-output logic for the reaction-game controller.
  always_comb begin
    state_d  = state_q;
    ms_cnt_d = ms_cnt_q;
    wait_d   = wait_q;
    sum_d    = sum_q;
    led_d    = led_q;
    num_d    = num_q;
    hi_d     = hi_q;
    done_d   = done_q;
    round_d  = round_q;
    best_d   = best_q;

    case (state_q)
      IDLE, SHOW_TIME, SHOW_JUMP, SHOW_TIMEOUT, SHOW_AVG: begin
        if (start) begin
          // Only SHOW_TIME continues a series; every other state starts fresh.
          if (state_q != SHOW_TIME) begin
            sum_d   = '0;
            round_d = 4'd0;
          end else begin
            sum_d   = sum_q;
            round_d = round_q;
          end
          done_d   = 1'b0;
          hi_d     = 1'b0;
          led_d    = 1'b0;
          num_d    = '0;
          wait_d   = RAND_MIN_V + CNT_W'(lfsr_s & RAND_MASK);
          ms_cnt_d = '0;
          state_d  = RAND_WAIT;
        end else begin
          state_d = state_q;
        end
      end

      RAND_WAIT: begin
        if (stop) begin
          num_d   = NINES_V;
          hi_d    = 1'b1;
          state_d = SHOW_JUMP;
        end else if (ms_cnt_q == wait_q) begin
          led_d    = 1'b1;
          ms_cnt_d = '0;
          state_d  = PRESS_WAIT;
        end else if (ms_tick) begin
          ms_cnt_d = ms_cnt_q + CNT_ONE;
        end else begin
          ms_cnt_d = ms_cnt_q;
        end
      end

      PRESS_WAIT: begin
        if (stop) begin
          // A tick arriving with stop is not counted: record ms_cnt as-is.
          led_d  = 1'b0;
          sum_d  = sum_new_s;
          best_d = best_next_s;
          if (round_q == LAST_ROUND) begin
            num_d   = CNT_W'(sum_new_s >> AVG_SH);
            done_d  = 1'b1;
            state_d = SHOW_AVG;
          end else begin
            num_d   = ms_cnt_q;
            round_d = round_q + 4'd1;
            state_d = SHOW_TIME;
          end
        end else if (ms_cnt_q == TIMEOUT_V) begin
          led_d   = 1'b0;
          num_d   = TIMEOUT_V;
          hi_d    = 1'b1;
          state_d = SHOW_TIMEOUT;
        end else if (ms_tick) begin
          ms_cnt_d = ms_cnt_q + CNT_ONE;
          num_d    = ms_cnt_q + CNT_ONE;
        end else begin
          ms_cnt_d = ms_cnt_q;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ms_cnt_q <= '0;
      wait_q   <= '0;
      sum_q    <= '0;
      led_q    <= 1'b0;
      num_q    <= '0;
      hi_q     <= 1'b0;
      done_q   <= 1'b0;
      round_q  <= 4'd0;
      best_q   <= {CNT_W{1'b1}};
    end else begin
      state_q  <= state_d;
      ms_cnt_q <= ms_cnt_d;
      wait_q   <= wait_d;
      sum_q    <= sum_d;
      led_q    <= led_d;
      num_q    <= num_d;
      hi_q     <= hi_d;
      done_q   <= done_d;
      round_q  <= round_d;
      best_q   <= best_d;
    end
  end

  assign led       = led_q;
  assign num       = num_q;
  assign hi        = hi_q;
  assign done      = done_q;
  assign round_idx = round_q;
  assign best      = best_q;

endmodule

// File: tb/tb_reaction_timer_fsm.sv
// -----------------------------------------------------------------------------
// tb_reaction_timer_fsm
// Directed scenarios plus a randomized run of start/stop/rst, with every output
// compared on each falling edge against a behavioural game model.
// -----------------------------------------------------------------------------
module tb_reaction_timer_fsm;

  localparam int TO   = 20;
  localparam int RMIN = 5;
  localparam int RW   = 2;
  localparam int NIN  = 9999;
  localparam int RND  = 4;
`ifdef REACTION_BEST_EN
  localparam int EXP_BEST = 10;
`else
  localparam int EXP_BEST = 'hFFFF;
`endif

  // model phases of the game
  localparam int M_OFF = 0, M_DELAY = 1, M_REACT = 2, M_SCORE = 3,
                 M_FALSE = 4, M_SLOW = 5, M_FINAL = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1, ms_tick = 1'b0, start = 1'b0, stop = 1'b0;
  logic        led, hi, done;
  logic [15:0] num, best;
  logic [3:0]  round_idx;

  int checks = 0, errors = 0, cyc = 0;
  bit m_valid = 0, last_tick = 0;

  int m_phase = M_OFF, m_lfsr = 'hACE1, m_target = 0, m_ticks = 0;
  int m_times[$];
  int e_led = 0, e_num = 0, e_hi = 0, e_done = 0, e_round = 0, e_best = 'hFFFF;

  reaction_timer_fsm #(
    .CNT_W(16), .TIMEOUT_MS(TO), .RAND_MIN_MS(RMIN), .RAND_W(RW),
    .NINES(NIN), .ROUNDS(RND)
  ) dut (
    .clk(clk), .rst(rst), .ms_tick(ms_tick), .start(start), .stop(stop),
    .led(led), .num(num), .hi(hi), .done(done), .round_idx(round_idx),
    .best(best)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Behavioural game model, advanced once per clock with that cycle's inputs.
  task automatic model_step(input bit r, input bit tk, input bit s, input bit p);
    int lf, total;
    lf = m_lfsr;
    m_lfsr = (lf >> 1) ^ (((lf & 1) != 0) ? 'hB400 : 0);
    if (r) begin
      m_phase = M_OFF; m_lfsr = 'hACE1; m_times.delete(); m_ticks = 0;
      e_led = 0; e_num = 0; e_hi = 0; e_done = 0; e_round = 0; e_best = 'hFFFF;
      return;
    end
    case (m_phase)
      M_DELAY: begin
        if (p) begin
          m_phase = M_FALSE; e_num = NIN; e_hi = 1;
        end else if (m_ticks == m_target) begin
          e_led = 1; m_ticks = 0; m_phase = M_REACT;
        end else if (tk) m_ticks++;
      end
      M_REACT: begin
        if (p) begin
          e_led = 0;
          m_times.push_back(m_ticks);
`ifdef REACTION_BEST_EN
          if (m_ticks < e_best) e_best = m_ticks;
`endif
          if (m_times.size() == RND) begin
            total = 0;
            foreach (m_times[i]) total += m_times[i];
            e_num = total / RND; e_done = 1; m_phase = M_FINAL;
          end else begin
            e_num = m_ticks; e_round = m_times.size(); m_phase = M_SCORE;
          end
        end else if (m_ticks == TO) begin
          e_led = 0; e_num = TO; e_hi = 1; m_phase = M_SLOW;
        end else if (tk) begin
          m_ticks++; e_num = m_ticks;
        end
      end
      default: begin
        if (s) begin
          if (m_phase != M_SCORE) m_times.delete();
          e_hi = 0; e_done = 0; e_num = 0; e_led = 0; e_round = m_times.size();
          m_target = RMIN + (lf % (1 << RW)); m_ticks = 0; m_phase = M_DELAY;
        end
      end
    endcase
  endtask

  task automatic cycle(input bit r, input bit s, input bit p);
    rst = r; start = s; stop = p; ms_tick = ((cyc % 4) == 3);
    last_tick = ms_tick;
    @(posedge clk);
    model_step(r, last_tick, s, p);
    cyc++;
    m_valid = 1;
    #1;
  endtask

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("m_led", led, e_led);
      chk("m_num", num, e_num);
      chk("m_hi", hi, e_hi);
      chk("m_done", done, e_done);
      chk("m_round", round_idx, e_round);
      chk("m_best", best, e_best);
    end
  end

  task automatic wait_led();
    for (int i = 0; i < 200 && led !== 1'b1; i++) cycle(0, 0, 0);
    chk("led_rise", led, 1);
  endtask

  // Press stop once t ticks have been counted; optionally together with tick t+1.
  task automatic react(input int t, input bit same_tick);
    int n = 0;
    while (n < t) begin
      cycle(0, 0, 0);
      if (last_tick) n++;
    end
    if (same_tick) begin
      while ((cyc % 4) != 3) cycle(0, 0, 0);
    end
    cycle(0, 0, 1);
  endtask

  task automatic do_round(input int t);
    cycle(0, 1, 0);
    wait_led();
    react(t, 0);
  endtask

  initial begin
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    chk("rst_led", led, 0);  chk("rst_num", num, 0);   chk("rst_hi", hi, 0);
    chk("rst_done", done, 0); chk("rst_round", round_idx, 0);
    chk("rst_best", best, 'hFFFF);

    // reset in the middle of PRESS_WAIT
    cycle(0, 1, 0);
    wait_led();
    repeat (6) cycle(0, 0, 0);
    cycle(1, 0, 0);
    chk("midrst_led", led, 0); chk("midrst_num", num, 0); chk("midrst_round", round_idx, 0);
    cycle(0, 0, 1);
    chk("idle_stop_hi", hi, 0); chk("idle_stop_num", num, 0);

    // valid round of 7 ms
    do_round(7);
    chk("t7_num", num, 7); chk("t7_hi", hi, 0); chk("t7_round", round_idx, 1);

    // false start
    cycle(0, 1, 0);
    repeat (3) cycle(0, 0, 0);
    cycle(0, 0, 1);
    chk("jump_num", num, NIN); chk("jump_hi", hi, 1); chk("jump_led", led, 0);
    cycle(0, 1, 0);
    chk("jump_next_round", round_idx, 0); chk("jump_next_hi", hi, 0);

    // timeout
    wait_led();
    for (int i = 0; i < 200 && hi !== 1'b1; i++) cycle(0, 0, 0);
    chk("to_num", num, TO); chk("to_hi", hi, 1); chk("to_led", led, 0);

    // stop together with the 20th tick
    cycle(0, 1, 0);
    wait_led();
    react(19, 1);
    chk("edge_num", num, 19); chk("edge_hi", hi, 0); chk("edge_round", round_idx, 1);

    // full series 10, 11, 12, 15
    cycle(1, 0, 0);
    do_round(10); do_round(11); do_round(12); do_round(15);
    chk("avg_done", done, 1); chk("avg_num", num, 12);
    chk("avg_round", round_idx, 3); chk("avg_best", best, EXP_BEST);

    // start during RAND_WAIT is ignored
    cycle(0, 1, 0);
    repeat (5) cycle(0, 0, 0);
    cycle(0, 1, 0);
    chk("ign_round", round_idx, 0); chk("ign_done", done, 0); chk("ign_hi", hi, 0);
    wait_led();
    react(3, 0);
    chk("ign_num", num, 3); chk("ign_round2", round_idx, 1);

    // randomized play
    for (int i = 0; i < 5000; i++) begin
      cycle(($urandom % 700) == 0, ($urandom % 25) == 0, ($urandom % 20) == 0);
    end

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
